// File: rtl/cw_encode_arbiter_pkg.sv
// Shared constants and the 4-to-7 bit linear codeword encoder.
// The encoder output is the XOR of one generator row for each set data bit.
package cw_encode_arbiter_pkg;

    localparam int unsigned CW_W   = 7;
    localparam int unsigned DATA_W = 4;

    localparam logic [CW_W-1:0] GEN_D3 = 7'b1001011;
    localparam logic [CW_W-1:0] GEN_D2 = 7'b0101010;
    localparam logic [CW_W-1:0] GEN_D1 = 7'b0011001;
    localparam logic [CW_W-1:0] GEN_D0 = 7'b0000111;

    function automatic logic [CW_W-1:0] enc(input logic [DATA_W-1:0] d);
        logic [CW_W-1:0] cw;
        cw = '0;
        if (d[3]) cw = cw ^ GEN_D3;
        if (d[2]) cw = cw ^ GEN_D2;
        if (d[1]) cw = cw ^ GEN_D1;
        if (d[0]) cw = cw ^ GEN_D0;
        return cw;
    endfunction

endpackage

// File: rtl/cw_encode_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request scanning circularly from ptr.
// The index wraps through its natural width, so NREQ must be a power of two.
module rr_pick #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned SRC_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [SRC_W-1:0] ptr,
    output logic             any,
    output logic [SRC_W-1:0] gnt
);

    logic [SRC_W-1:0] idx;

    always_comb begin
        any = 1'b0;
        gnt = '0;
        idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = ptr + k[SRC_W-1:0];
            if (!any && req[idx]) begin
                any = 1'b1;
                gnt = idx;
            end
        end
    end

endmodule

// File: rtl/cw_encode_arbiter.sv
// Round-robin shared codeword encoder with a registered valid/ready output port.
// One nibble is accepted per cycle whenever the output register is empty or draining.
module cw_encode_arbiter
    import cw_encode_arbiter_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned SRC_W = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [DATA_W*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CW_W-1:0]          out_code,
    output logic [SRC_W-1:0]         out_src,
    output logic [CNT_W-1:0]         grant_cnt
);

    logic [SRC_W-1:0]  ptr;
    logic [SRC_W-1:0]  gnt;
    logic              any;
    logic              load_en;
    logic              accept;
    logic [DATA_W-1:0] sel_data;

    rr_pick #(
        .NREQ  (NREQ),
        .SRC_W (SRC_W)
    ) u_rr_pick (
        .req (req_valid),
        .ptr (ptr),
        .any (any),
        .gnt (gnt)
    );

    assign load_en = !out_valid || out_ready;
    // Reset forces every ready low so nothing is accepted while rst is high.
    assign accept  = any && load_en && !rst;

    always_comb begin
        sel_data  = '0;
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt == i[SRC_W-1:0]) begin
                sel_data     = req_data[i*DATA_W +: DATA_W];
                req_ready[i] = accept;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_code  <= '0;
            out_src   <= '0;
            grant_cnt <= '0;
            ptr       <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_code  <= enc(sel_data);
            out_src   <= gnt;
            ptr       <= gnt + 1'b1;
            grant_cnt <= grant_cnt + 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
